bp_zynq_mem_burst_arbiter: RTL and testbench
============================================

Name: bp_zynq_mem_burst_arbiter

Overview:
- Shares the single 64-bit memory-side BedRock stream port among num_req_p requesters (cores/CCEs in the multicore ZynqParrot configurations).
- Grants whole bursts round-robin and holds the lock until the burst's last beat.
- Records each granted requester ID in an in-order ID FIFO and uses it to steer the returning response streams back to their owners.
- Sits between the per-core memory stream outputs and the shell's memory/DRAM adapter.

Parameters:
- num_req_p, 4, number of requesters; must be at least 2.
- data_width_p, 64, stream beat width in bits; equals bedrock_fill_width.
- id_fifo_els_p, 8, maximum number of outstanding bursts; must be a power of 2.
- lg_num_req_lp, derived as $clog2(num_req_p), requester ID width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- req_v_i  in  num_req_p  per-requester beat valid.
- req_data_i  in  num_req_p*data_width_p  per-requester beat data; requester k occupies slice k.
- req_last_i  in  num_req_p  per-requester last beat of burst.
- req_ready_o  out  num_req_p  per-requester beat accept.
- mem_req_v_o  out  1  merged stream valid.
- mem_req_data_o  out  data_width_p  merged stream data.
- mem_req_last_o  out  1  merged stream last beat.
- mem_req_id_o  out  lg_num_req_lp  requester ID of the current burst.
- mem_req_ready_i  in  1  downstream accept.
- mem_resp_v_i  in  1  response beat valid.
- mem_resp_data_i  in  data_width_p  response beat data.
- mem_resp_last_i  in  1  last beat of response.
- mem_resp_ready_o  out  1  response accept.
- resp_v_o  out  num_req_p  steered response valid; one-hot or zero.
- resp_data_o  out  data_width_p  response data broadcast to all requesters.
- resp_last_o  out  1  response last beat, broadcast.
- resp_ready_i  in  num_req_p  per-requester response accept.

Behaviour:
- Reset (async, aresetn=0):
  - State = IDLE, rr_ptr = 0, grant_id = 0, ID FIFO empty.
  - All *_v_o, *_ready_o and mem_req_last_o are 0.
  - Data outputs are don't-care.
- State machine, two states:
  - IDLE: no request is forwarded. If any req_v_i bit is 1 and the FIFO is not full:
    - Winner = first set bit scanning from rr_ptr upward, with wrap.
    - grant_id <= winner; winner is pushed into the ID FIFO; next state = LOCK.
    - Grant is based on valid only; the first beat is not consumed in IDLE.
  - LOCK:
    - mem_req_v_o = req_v_i[grant_id]; data and last come from slice grant_id; mem_req_id_o = grant_id.
    - req_ready_o[grant_id] = mem_req_ready_i; all other ready bits are 0.
    - On a handshake with last=1: next state = IDLE, rr_ptr <= grant_id+1 (wraps to 0 at num_req_p).
- Latency: request-to-first-beat is one cycle. There is one dead cycle in IDLE between consecutive bursts.
- Protocol rules:
  - A requester must not drop valid mid-burst. A zero-valid cycle in LOCK holds the lock.
  - A single-beat burst (last on first beat) is legal and returns to IDLE after one LOCK cycle.
- Response path:
  - head = ID FIFO head.
  - If the FIFO is empty: mem_resp_ready_o = 0 and resp_v_o = 0.
  - Otherwise: resp_v_o[head] = mem_resp_v_i, mem_resp_ready_o = resp_ready_i[head].
  - On a response handshake with last=1, the FIFO head is popped.
  - Every granted burst produces exactly one response stream, including writes, which return an ack.
- FIFO boundaries:
  - Full is taken from registered count; a pop in the same cycle does not enable a grant.
  - No bypass: a response cannot be accepted in the cycle its ID is pushed into an empty FIFO.
  - Pointers wrap modulo id_fifo_els_p.
  - Simultaneous push and pop leaves the count unchanged.
- Reset asserted mid-burst aborts the lock immediately and discards all outstanding IDs.

Optional Feature:
- Macro: BP_ZYNQ_ARB_PERF_CNT_EN.
- Defined:
  - Adds output grant_cnt_o [num_req_p*32].
  - Holds one 32-bit saturating counter per requester, incremented on each IDLE->LOCK grant to that requester.
  - Counters are cleared by reset; they hold at 0xFFFFFFFF.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Single requester 1 issues a 4-beat burst; mem_req_ready_i=1 -> mem_req_id_o=1 with 4 beats on the consecutive cycles after grant; FIFO holds {1}; a 4-beat response asserts only resp_v_o[1]; FIFO ends empty.
- All 4 requesters hold continuous 2-beat bursts -> grant order 0,1,2,3,0; each burst is followed by exactly one IDLE cycle.
- id_fifo_els_p=2, responses withheld, requesters 0,1,2 pending -> grants 0 and 1 only; requester 2 is granted two cycles after the first response last-handshake (pop cycle, then IDLE grant cycle).
- In LOCK on requester 3, drop req_v_i[3] for 3 cycles mid-burst while requester 0 is valid -> grant held on 3, req_ready_o[0]=0 throughout, burst completes intact.
- Assert aresetn=0 mid-burst with 2 IDs outstanding -> all valid/ready outputs are 0 immediately; after release, a new burst from requester 2 is granted and its response routes to requester 2.
- Perf macro defined: 5 grants to requester 0 -> grant_cnt_o slice 0 = 5, other slices = 0.

Source files
------------

// File: rtl/bp_zynq_mem_burst_arbiter_if.sv
// bp_zynq_mem_burst_arbiter_if: requester-side and memory-side streams.
// slave = arbiter view, master = requester/memory environment view.
interface bp_zynq_mem_burst_arbiter_if #(
  parameter int num_req_p = 4,
  parameter int data_width_p = 64
);
  localparam int lg_num_req_lp = $clog2(num_req_p);

  logic [num_req_p-1:0] req_v_i;
  logic [num_req_p*data_width_p-1:0] req_data_i;
  logic [num_req_p-1:0] req_last_i;
  logic [num_req_p-1:0] req_ready_o;

  logic mem_req_v_o;
  logic [data_width_p-1:0] mem_req_data_o;
  logic mem_req_last_o;
  logic [lg_num_req_lp-1:0] mem_req_id_o;
  logic mem_req_ready_i;

  logic mem_resp_v_i;
  logic [data_width_p-1:0] mem_resp_data_i;
  logic mem_resp_last_i;
  logic mem_resp_ready_o;

  logic [num_req_p-1:0] resp_v_o;
  logic [data_width_p-1:0] resp_data_o;
  logic resp_last_o;
  logic [num_req_p-1:0] resp_ready_i;

  modport slave (
    input  req_v_i, req_data_i, req_last_i,
    output req_ready_o,
    output mem_req_v_o, mem_req_data_o,
    output mem_req_last_o, mem_req_id_o,
    input  mem_req_ready_i,
    input  mem_resp_v_i, mem_resp_data_i,
    input  mem_resp_last_i,
    output mem_resp_ready_o,
    output resp_v_o, resp_data_o, resp_last_o,
    input  resp_ready_i
  );

  modport master (
    output req_v_i, req_data_i, req_last_i,
    input  req_ready_o,
    input  mem_req_v_o, mem_req_data_o,
    input  mem_req_last_o, mem_req_id_o,
    output mem_req_ready_i,
    output mem_resp_v_i, mem_resp_data_i,
    output mem_resp_last_i,
    input  mem_resp_ready_o,
    input  resp_v_o, resp_data_o, resp_last_o,
    output resp_ready_i
  );
endinterface

// File: rtl/bp_zynq_mem_burst_arbiter.sv
// bp_zynq_mem_burst_arbiter: round-robin burst arbiter with in-order ID FIFO.
// Optional BP_ZYNQ_ARB_PERF_CNT_EN adds per-requester grant counters.
module bp_zynq_mem_burst_arbiter #(
  parameter int num_req_p = 4,
  parameter int data_width_p = 64,
  parameter int id_fifo_els_p = 8
) (
  input logic aclk,
  input logic aresetn,
  bp_zynq_mem_burst_arbiter_if.slave bus
`ifdef BP_ZYNQ_ARB_PERF_CNT_EN
  ,
  output logic [num_req_p*32-1:0] grant_cnt_o
`endif
);
  localparam int lg_num_req_lp = $clog2(num_req_p);
  localparam int lg_els_lp =
    (id_fifo_els_p > 1) ? $clog2(id_fifo_els_p) : 1;
  localparam int cnt_w_lp = $clog2(id_fifo_els_p + 1);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e state_q, state_n;
  logic [lg_num_req_lp-1:0] rr_ptr_q, grant_id_q;
  logic [lg_num_req_lp-1:0] winner, cand, rr_next;
  logic found;

  logic [lg_num_req_lp-1:0] fifo_mem [id_fifo_els_p];
  logic [lg_els_lp-1:0] wptr_q, rptr_q;
  logic [cnt_w_lp-1:0] cnt_q;
  logic [lg_num_req_lp-1:0] head;
  logic full, empty, push, pop, burst_done;

  assign full  = (cnt_q == cnt_w_lp'(id_fifo_els_p));
  assign empty = (cnt_q == '0);
  assign head  = fifo_mem[rptr_q];

  assign push = (state_q == IDLE) && found && !full;

  assign burst_done = (state_q == LOCK)
    && bus.req_v_i[grant_id_q]
    && bus.mem_req_ready_i
    && bus.req_last_i[grant_id_q];

  assign pop = !empty && bus.mem_resp_v_i
    && bus.resp_ready_i[head] && bus.mem_resp_last_i;

  assign rr_next =
    (grant_id_q == lg_num_req_lp'(num_req_p - 1))
      ? '0 : grant_id_q + 1'b1;

  // Round-robin pick: first valid requester at or after rr_ptr.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      cand = lg_num_req_lp'((int'(rr_ptr_q) + i) % num_req_p);
      if (!found && bus.req_v_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_n;
  end

  // Next state: lock on grant, release on the last beat handshake.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: if (push) state_n = LOCK;
      LOCK: if (burst_done) state_n = IDLE;
    endcase
  end

  // Grant bookkeeping and ID FIFO pointers/count.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < id_fifo_els_p; i++)
        fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        grant_id_q       <= winner;
        fifo_mem[wptr_q] <= winner;
        wptr_q <= (wptr_q == lg_els_lp'(id_fifo_els_p - 1))
          ? '0 : wptr_q + 1'b1;
      end
      if (burst_done) rr_ptr_q <= rr_next;
      if (pop)
        rptr_q <= (rptr_q == lg_els_lp'(id_fifo_els_p - 1))
          ? '0 : rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Outputs: forward the locked requester, steer responses by FIFO head.
  always_comb begin
    bus.req_ready_o    = '0;
    bus.mem_req_v_o    = 1'b0;
    bus.mem_req_last_o = 1'b0;
    bus.mem_req_id_o   = grant_id_q;
    bus.mem_req_data_o =
      bus.req_data_i[grant_id_q*data_width_p +: data_width_p];
    bus.mem_resp_ready_o = 1'b0;
    bus.resp_v_o         = '0;
    bus.resp_data_o      = bus.mem_resp_data_i;
    bus.resp_last_o      = bus.mem_resp_last_i;
    if (state_q == LOCK) begin
      bus.mem_req_v_o    = bus.req_v_i[grant_id_q];
      bus.mem_req_last_o = bus.req_last_i[grant_id_q];
      bus.req_ready_o[grant_id_q] = bus.mem_req_ready_i;
    end
    if (!empty) begin
      bus.resp_v_o[head]   = bus.mem_resp_v_i;
      bus.mem_resp_ready_o = bus.resp_ready_i[head];
    end
  end

`ifdef BP_ZYNQ_ARB_PERF_CNT_EN
  for (genvar k = 0; k < num_req_p; k++) begin : g_cnt
    logic [31:0] c_q;
    // Saturating count of grants to requester k.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
        c_q <= '0;
      else if (push && winner == lg_num_req_lp'(k) && c_q != '1)
        c_q <= c_q + 1'b1;
    end
    assign grant_cnt_o[k*32 +: 32] = c_q;
  end
`endif

endmodule

// File: tb/tb_bp_zynq_mem_burst_arbiter.sv
// tb_bp_zynq_mem_burst_arbiter: directed checks of grant, lock,
// ID FIFO steering, FIFO-full stall and reset abort.
module tb_bp_zynq_mem_burst_arbiter;
  localparam int NR = 4;
  localparam int DW = 64;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  bp_zynq_mem_burst_arbiter_if #(.num_req_p(NR), .data_width_p(DW)) b();
  bp_zynq_mem_burst_arbiter_if #(.num_req_p(NR), .data_width_p(DW)) b2();

`ifdef BP_ZYNQ_ARB_PERF_CNT_EN
  logic [NR*32-1:0] gcnt, gcnt2;
`endif

  bp_zynq_mem_burst_arbiter #(
    .num_req_p(NR), .data_width_p(DW), .id_fifo_els_p(8)
  ) u_dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(b)
`ifdef BP_ZYNQ_ARB_PERF_CNT_EN
    , .grant_cnt_o(gcnt)
`endif
  );

  bp_zynq_mem_burst_arbiter #(
    .num_req_p(NR), .data_width_p(DW), .id_fifo_els_p(2)
  ) u_dut2 (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(b2)
`ifdef BP_ZYNQ_ARB_PERF_CNT_EN
    , .grant_cnt_o(gcnt2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic rst_pulse();
    aresetn = 1'b0;
    step();
    step();
    aresetn = 1'b1;
  endtask

  initial begin
    b.req_v_i = '0; b.req_data_i = '0; b.req_last_i = '0;
    b.mem_req_ready_i = 1'b1;
    b.mem_resp_v_i = 1'b1; b.mem_resp_data_i = '0;
    b.mem_resp_last_i = 1'b1; b.resp_ready_i = '1;
    b2.req_v_i = '0; b2.req_data_i = '0; b2.req_last_i = '0;
    b2.mem_req_ready_i = 1'b1;
    b2.mem_resp_v_i = 1'b0; b2.mem_resp_data_i = '0;
    b2.mem_resp_last_i = 1'b0; b2.resp_ready_i = '1;
    aresetn = 1'b0;
    step();
    step();
    chk("rst_mem_v", b.mem_req_v_o, 0);
    chk("rst_req_rdy", b.req_ready_o, 0);
    chk("rst_resp_rdy", b.mem_resp_ready_o, 0);
    chk("rst_resp_v", b.resp_v_o, 0);
    chk("rst_last", b.mem_req_last_o, 0);
    aresetn = 1'b1;

    // Single 4-beat burst from requester 1.
    b.req_v_i = 4'b0010;
    #1;
    chk("t1_idle_v", b.mem_req_v_o, 0);
    chk("t1_nobypass_rdy", b.mem_resp_ready_o, 0);
    chk("t1_nobypass_v", b.resp_v_o, 0);
    step();
    b.mem_resp_v_i = 1'b0;
    for (int beat = 0; beat < 4; beat++) begin
      b.req_data_i[DW +: DW] = 64'h1111_0000_0000_0000 + 64'(beat);
      b.req_last_i[1] = (beat == 3);
      #1;
      chk("t1_id", b.mem_req_id_o, 1);
      chk("t1_v", b.mem_req_v_o, 1);
      chk("t1_rdy", b.req_ready_o, 4'b0010);
      chk("t1_data", b.mem_req_data_o,
          64'h1111_0000_0000_0000 + 64'(beat));
      chk("t1_last", b.mem_req_last_o, 64'(beat == 3));
      step();
    end
    b.req_v_i = '0;
    b.req_last_i = '0;
    #1;
    chk("t1_back_idle", b.mem_req_v_o, 0);
    chk("t1_idle_rdy", b.req_ready_o, 0);
    b.mem_resp_v_i = 1'b1;
    b.mem_resp_last_i = 1'b0;
    b.mem_resp_data_i = 64'hCAFE_F00D_0000_0001;
    b.resp_ready_i = 4'b1101;
    #1;
    chk("t1_resp_v", b.resp_v_o, 4'b0010);
    chk("t1_resp_rdy_steer", b.mem_resp_ready_o, 0);
    chk("t1_resp_data", b.resp_data_o, 64'hCAFE_F00D_0000_0001);
    step();
    b.resp_ready_i = 4'b0010;
    for (int r = 0; r < 4; r++) begin
      b.mem_resp_last_i = (r == 3);
      #1;
      chk("t1_resp_v_beat", b.resp_v_o, 4'b0010);
      chk("t1_resp_rdy", b.mem_resp_ready_o, 1);
      step();
    end
    b.resp_ready_i = '1;
    #1;
    chk("t1_fifo_empty_v", b.resp_v_o, 0);
    chk("t1_fifo_empty_rdy", b.mem_resp_ready_o, 0);
    b.mem_resp_v_i = 1'b0;

    // All four requesters with continuous 2-beat bursts.
    rst_pulse();
    for (int k = 0; k < NR; k++)
      b.req_data_i[k*DW +: DW] = {32'hA5A5_0000, 32'(k)};
    b.req_v_i = 4'hF;
    b.req_last_i = '0;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("t2_idle_gap", b.mem_req_v_o, 0);
      step();
      chk("t2_grant_id", b.mem_req_id_o, 64'(g % 4));
      chk("t2_rdy", b.req_ready_o, 64'(1 << (g % 4)));
      chk("t2_data", b.mem_req_data_o,
          {32'hA5A5_0000, 32'(g % 4)});
      chk("t2_first_last", b.mem_req_last_o, 0);
      step();
      b.req_last_i[g % 4] = 1'b1;
      #1;
      chk("t2_v_beat1", b.mem_req_v_o, 1);
      chk("t2_last", b.mem_req_last_o, 1);
      step();
      b.req_last_i[g % 4] = 1'b0;
      if (g == 4) b.req_v_i = '0;
      #1;
    end
    b.mem_resp_v_i = 1'b1;
    b.mem_resp_last_i = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("t2_resp_order", b.resp_v_o, 64'(1 << (g % 4)));
      chk("t2_resp_rdy", b.mem_resp_ready_o, 1);
      step();
    end
    chk("t2_drained_v", b.resp_v_o, 0);
    chk("t2_drained_rdy", b.mem_resp_ready_o, 0);
    b.mem_resp_v_i = 1'b0;

    // Lock on 3 holds through a valid gap while 0 waits.
    b.req_v_i = 4'b1001;
    b.req_last_i = '0;
    #1;
    chk("t4_idle", b.mem_req_v_o, 0);
    step();
    chk("t4_id", b.mem_req_id_o, 3);
    chk("t4_rdy", b.req_ready_o, 4'b1000);
    step();
    b.req_v_i[3] = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("t4_gap_v", b.mem_req_v_o, 0);
      chk("t4_gap_id", b.mem_req_id_o, 3);
      chk("t4_gap_rdy", b.req_ready_o, 4'b1000);
      step();
    end
    b.req_v_i[3] = 1'b1;
    b.req_last_i[3] = 1'b1;
    #1;
    chk("t4_resume_v", b.mem_req_v_o, 1);
    chk("t4_resume_last", b.mem_req_last_o, 1);
    chk("t4_resume_id", b.mem_req_id_o, 3);
    step();
    b.req_v_i[3] = 1'b0;
    b.req_last_i[3] = 1'b0;
    #1;
    chk("t4_idle_after", b.mem_req_v_o, 0);
    step();
    chk("t4_next_id", b.mem_req_id_o, 0);
    chk("t4_next_v", b.mem_req_v_o, 1);
    b.req_last_i[0] = 1'b1;
    step();
    b.req_v_i = '0;
    b.req_last_i = '0;

    // Reset mid-burst with two IDs outstanding.
    b.mem_resp_v_i = 1'b1;
    b.mem_resp_last_i = 1'b1;
    #1;
    chk("t5_resp3", b.resp_v_o, 4'b1000);
    step();
    b.mem_resp_v_i = 1'b0;
    b.req_v_i = 4'b0010;
    #1;
    step();
    chk("t5_lock1", b.mem_req_id_o, 1);
    step();
    b.mem_resp_v_i = 1'b1;
    aresetn = 1'b0;
    #1;
    chk("t5_rst_v", b.mem_req_v_o, 0);
    chk("t5_rst_rdy", b.req_ready_o, 0);
    chk("t5_rst_resp_rdy", b.mem_resp_ready_o, 0);
    chk("t5_rst_resp_v", b.resp_v_o, 0);
    step();
    aresetn = 1'b1;
    b.req_v_i = 4'b0100;
    b.mem_resp_v_i = 1'b0;
    #1;
    step();
    chk("t5_new_id", b.mem_req_id_o, 2);
    chk("t5_new_v", b.mem_req_v_o, 1);
    b.req_last_i[2] = 1'b1;
    #1;
    step();
    b.req_v_i = '0;
    b.req_last_i = '0;
    b.mem_resp_v_i = 1'b1;
    #1;
    chk("t5_resp_route", b.resp_v_o, 4'b0100);
    chk("t5_resp_rdy", b.mem_resp_ready_o, 1);
    step();
    chk("t5_resp_done", b.resp_v_o, 0);
    b.mem_resp_v_i = 1'b0;

    // Two-entry ID FIFO fills and stalls grants.
    b2.req_last_i = 4'b0111;
    b2.req_v_i = 4'b0111;
    #1;
    chk("t3_idle0", b2.mem_req_v_o, 0);
    step();
    chk("t3_g0_id", b2.mem_req_id_o, 0);
    chk("t3_g0_v", b2.mem_req_v_o, 1);
    step();
    b2.req_v_i = 4'b0110;
    #1;
    chk("t3_idle1", b2.mem_req_v_o, 0);
    step();
    chk("t3_g1_id", b2.mem_req_id_o, 1);
    chk("t3_g1_v", b2.mem_req_v_o, 1);
    step();
    b2.req_v_i = 4'b0100;
    #1;
    chk("t3_idle2", b2.mem_req_v_o, 0);
    step();
    chk("t3_full_a", b2.mem_req_v_o, 0);
    step();
    chk("t3_full_b", b2.mem_req_v_o, 0);
    b2.mem_resp_v_i = 1'b1;
    b2.mem_resp_last_i = 1'b1;
    #1;
    chk("t3_resp0", b2.resp_v_o, 4'b0001);
    step();
    chk("t3_pop_cycle", b2.mem_req_v_o, 0);
    chk("t3_resp1", b2.resp_v_o, 4'b0010);
    step();
    chk("t3_g2_id", b2.mem_req_id_o, 2);
    chk("t3_g2_v", b2.mem_req_v_o, 1);
    chk("t3_resp2_wrap", b2.resp_v_o, 4'b0100);
    step();
    chk("t3_empty_v", b2.resp_v_o, 0);
    chk("t3_empty_rdy", b2.mem_resp_ready_o, 0);
    b2.req_v_i = '0;
    b2.mem_resp_v_i = 1'b0;

`ifdef BP_ZYNQ_ARB_PERF_CNT_EN
    // Five single-beat grants to requester 0.
    rst_pulse();
    b.req_v_i = 4'b0001;
    b.req_last_i = 4'b0001;
    #1;
    for (int i = 0; i < 5; i++) begin
      step();
      step();
    end
    b.req_v_i = '0;
    b.req_last_i = '0;
    #1;
    chk("perf_cnt0", gcnt[31:0], 5);
    for (int k = 1; k < NR; k++)
      chk("perf_cnt_other", gcnt[k*32 +: 32], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
